mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
Upstream control stage for the 4:1 channel mux. Steps the mux select lines through channels 0..3. Waits a programmable settle time on each channel, then samples the mux output. Presents the four sampled bits as one frame on a valid/ready handshake for downstream logic.

Parameters:
SETTLE_CYCLES, 2, extra cycles the select lines are held before the mux output is sampled (legal range 0..15; 4-bit counter)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request one scan of channels 0..3; sampled only when not busy (or in handshake cycle, see below)
mux_out  input  1  output of the 4:1 mux being scanned
s1  output  1  mux select MSB
s0  output  1  mux select LSB
frame_data  output  4  sampled frame; bit k = mux_out while {s1,s0}==k
frame_valid  output  1  frame_data holds a completed frame
frame_ready  input  1  downstream accepts frame when high with frame_valid
busy  output  1  scan in progress or frame awaiting acceptance

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high. All state is cleared immediately on rst=1, independent of clk.
- Reset values: s1=0, s0=0, frame_data=4'b0000, frame_valid=0, busy=0. State is IDLE. The shadow register, channel index and settle counter are all 0.
- States: IDLE, SETTLE, SAMPLE, HOLD.
- IDLE: on the edge with start=1:
  - go to SETTLE
  - set channel=0, {s1,s0}=00, counter=0, busy=1
  - start=0 keeps the block in IDLE.
- SETTLE: the counter increments each edge. When counter==SETTLE_CYCLES, go to SAMPLE. With SETTLE_CYCLES=0, SETTLE lasts 0 cycles, so the first state after IDLE is effectively SAMPLE.
- SAMPLE (one cycle):
  - on its edge, mux_out is written into shadow bit [channel].
  - channel<3: channel increments, {s1,s0} takes the new channel value, counter clears, go to SETTLE.
  - channel==3: copy shadow into frame_data (shadow bit 3 taken from this edge's mux_out), set frame_valid=1, set {s1,s0}=00, go to HOLD.
- Timing:
  - {s1,s0} are held stable for exactly SETTLE_CYCLES+1 cycles per channel.
  - frame_valid rises 4*(SETTLE_CYCLES+1) edges after the edge that accepted start. With default 2, that is 12 edges.
- HOLD:
  - frame_valid and frame_data are held stable until an edge where frame_ready=1.
  - On that edge frame_valid goes to 0.
  - If start=0 on that edge: busy goes to 0 and the block returns to IDLE.
  - If start=1 on that same edge: a new scan begins immediately, identical to the IDLE start transition. busy stays 1.
- frame_data changes only on the edge where frame_valid rises. It is never updated mid-scan or while held.
- frame_ready is ignored while frame_valid=0.
- start is ignored in SETTLE and SAMPLE, and in HOLD without frame_ready.
- mux_out is ignored outside SAMPLE.
- rst mid-scan or mid-HOLD:
  - the partial or pending frame is discarded and all outputs return to reset values.
  - the first edge after rst deasserts is treated as IDLE.
- busy=1 in SETTLE, SAMPLE and HOLD; busy=0 in IDLE only.

Test Plan:
- rst pulse at arbitrary time → s1=s0=0, frame_data=0000, frame_valid=0, busy=0 asynchronously (before next clk edge).
- SETTLE_CYCLES=2; bench models the mux with i0=1, i1=0, i2=1, i3=1; pulse start for 1 cycle, frame_ready=1:
  - {s1,s0} sequence is 00×3, 01×3, 10×3, 11×3 cycles.
  - frame_valid rises 12 edges after start with frame_data=4'b1101.
  - valid is high for 1 cycle; busy falls on the same edge.
- Backpressure: frame_ready=0 for 5 cycles after valid; toggle i0..i3 and pulse start in that window:
  - frame_valid stays 1 and frame_data stays 1101; no new scan starts.
  - frame_ready=1 clears valid on the next edge.
- Back-to-back: hold start=1 through HOLD with frame_ready=1:
  - valid drops, busy stays 1, {s1,s0}=00 restarts.
  - the second frame (inputs changed to 0010) appears 12 edges later as frame_data=0010.
- Reset mid-scan: assert rst 6 cycles after start (during channel 1):
  - outputs reset immediately and no frame_valid occurs.
  - after deassert, a new start yields the correct full frame in 12 edges.
- SETTLE_CYCLES=0 instance: selects change every cycle; with inputs 0110, frame_valid rises 4 edges after start with frame_data=4'b0110.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a 4:1 channel mux: steps the selects through channels 0..3,
// waits a settle time on each, samples the mux output and offers the 4-bit frame
// on a valid/ready handshake.
module mux_scan_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       mux_out,
   output logic       s1,
   output logic       s0,
   output logic [3:0] frame_data,
   output logic       frame_valid,
   input  logic       frame_ready,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      HOLD
   } state_t;

   // With no settle time each channel goes straight to SAMPLE, so SETTLE is skipped.
   localparam state_t     scan_entry  = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
   localparam logic [3:0] settle_last = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

   state_t     state, state_nxt;
   logic [1:0] channel, channel_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [3:0] shadow, shadow_nxt;
   logic [3:0] data_nxt;
   logic       valid_nxt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values; the small shadow register is reset like the other state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         channel     <= 2'd0;
         cnt         <= 4'd0;
         shadow      <= 4'd0;
         frame_data  <= 4'd0;
         frame_valid <= 1'b0;
      end else begin
         state       <= state_nxt;
         channel     <= channel_nxt;
         cnt         <= cnt_nxt;
         shadow      <= shadow_nxt;
         frame_data  <= data_nxt;
         frame_valid <= valid_nxt;
      end
   end

   // NOTE: every value is defaulted to its current state first, so no path
   // through the case statement can infer a latch.
   always_comb begin
      state_nxt   = state;
      channel_nxt = channel;
      cnt_nxt     = cnt;
      shadow_nxt  = shadow;
      data_nxt    = frame_data;
      valid_nxt   = frame_valid;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt   = scan_entry;
               channel_nxt = 2'd0;
               cnt_nxt     = 4'd0;
            end
         end

         SETTLE: begin
            cnt_nxt = cnt + 4'd1;
            if (cnt == settle_last) begin
               state_nxt = SAMPLE;
            end
         end

         SAMPLE: begin
            shadow_nxt[channel] = mux_out;
            cnt_nxt             = 4'd0;
            if (channel == 2'd3) begin
               // Bit 3 comes straight from mux_out; the shadow copy lands a cycle late.
               data_nxt    = {mux_out, shadow[2:0]};
               valid_nxt   = 1'b1;
               channel_nxt = 2'd0;
               state_nxt   = HOLD;
            end else begin
               channel_nxt = channel + 2'd1;
               state_nxt   = scan_entry;
            end
         end

         HOLD: begin
            if (frame_ready) begin
               valid_nxt = 1'b0;
               if (start) begin
                  state_nxt   = scan_entry;
                  channel_nxt = 2'd0;
                  cnt_nxt     = 4'd0;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   assign s1   = channel[1];
   assign s0   = channel[0];
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: a SETTLE_CYCLES=2 instance driven from a
// vector table plus corner sequences, and a SETTLE_CYCLES=0 instance.
module tb_mux_scan_sequencer;

   logic       clk;
   logic       rst;

   logic       start2, ready2, mux_out2, s1_2, s0_2, valid2, busy2;
   logic [3:0] data2, mux_in2;
   logic       start0, ready0, mux_out0, s1_0, s0_0, valid0, busy0;
   logic [3:0] data0, mux_in0;

   int         errors = 0;
   int         checks = 0;
   logic [3:0] held;

   typedef struct {
      logic [3:0] pat;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[6];

   mux_scan_sequencer #(.SETTLE_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .mux_out(mux_out2),
      .s1(s1_2), .s0(s0_2), .frame_data(data2), .frame_valid(valid2),
      .frame_ready(ready2), .busy(busy2)
   );

   mux_scan_sequencer #(.SETTLE_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .mux_out(mux_out0),
      .s1(s1_0), .s0(s0_0), .frame_data(data0), .frame_valid(valid0),
      .frame_ready(ready0), .busy(busy0)
   );

   // Mux models: input k is bit k of the pattern
   assign mux_out2 = mux_in2[{s1_2, s0_2}];
   assign mux_out0 = mux_in0[{s1_0, s0_0}];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (time %0t, limit 200000)", $time);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called just after the edge that accepted start; ends just after the valid edge.
   task automatic scan_body(input logic [3:0] exp);
      for (int n = 0; n < 12; n++) begin
         if (n > 0) tick();
         check("sel_seq", {30'd0, s1_2, s0_2}, 32'(n / 3));
         check("busy_scan", {31'd0, busy2}, 32'd1);
         check("valid_low_scan", {31'd0, valid2}, 32'd0);
         check("data_stable_scan", {28'd0, data2}, {28'd0, held});
      end
      tick();
      check("valid_rise", {31'd0, valid2}, 32'd1);
      check("frame_data", {28'd0, data2}, {28'd0, exp});
      check("sel_hold", {30'd0, s1_2, s0_2}, 32'd0);
      check("busy_hold", {31'd0, busy2}, 32'd1);
      held = exp;
   endtask

   task automatic start_scan(input logic [3:0] pat, input logic [3:0] exp);
      mux_in2 = pat;
      start2  = 1'b1;
      tick();
      start2  = 1'b0;
      scan_body(exp);
   endtask

   task automatic accept_frame();
      ready2 = 1'b1;
      tick();
      check("valid_fall", {31'd0, valid2}, 32'd0);
      check("busy_fall", {31'd0, busy2}, 32'd0);
      check("sel_idle", {30'd0, s1_2, s0_2}, 32'd0);
   endtask

   initial begin
      vecs[0] = '{pat: 4'b1101, exp: 4'b1101};
      vecs[1] = '{pat: 4'b0010, exp: 4'b0010};
      vecs[2] = '{pat: 4'b1111, exp: 4'b1111};
      vecs[3] = '{pat: 4'b0000, exp: 4'b0000};
      vecs[4] = '{pat: 4'b1010, exp: 4'b1010};
      vecs[5] = '{pat: 4'b0101, exp: 4'b0101};

      rst = 1'b0; start2 = 1'b0; ready2 = 1'b1; mux_in2 = 4'b0000;
      start0 = 1'b0; ready0 = 1'b1; mux_in0 = 4'b0000;
      held = 4'b0000;

      // Asynchronous reset before any clock edge
      #2 rst = 1'b1;
      #1;
      check("rst_sel", {30'd0, s1_2, s0_2}, 32'd0);
      check("rst_data", {28'd0, data2}, 32'd0);
      check("rst_valid", {31'd0, valid2}, 32'd0);
      check("rst_busy", {31'd0, busy2}, 32'd0);
      #10 rst = 1'b0;
      tick();
      check("idle_busy", {31'd0, busy2}, 32'd0);

      // Table-driven full scans with frame_ready held high
      for (int v = 0; v < 6; v++) begin
         start_scan(vecs[v].pat, vecs[v].exp);
         accept_frame();
      end

      // Backpressure: frame held, inputs and start ignored
      start_scan(4'b1101, 4'b1101);
      ready2 = 1'b0;
      for (int n = 0; n < 5; n++) begin
         mux_in2 = ~mux_in2;
         start2  = n[0];
         tick();
         check("bp_valid", {31'd0, valid2}, 32'd1);
         check("bp_data", {28'd0, data2}, 32'b1101);
         check("bp_sel", {30'd0, s1_2, s0_2}, 32'd0);
      end
      start2 = 1'b0;
      accept_frame();
      tick();
      check("bp_no_rescan", {31'd0, busy2}, 32'd0);

      // Back-to-back: start held through the accepting edge
      start_scan(4'b1101, 4'b1101);
      mux_in2 = 4'b0010;
      start2  = 1'b1;
      ready2  = 1'b1;
      tick();
      start2  = 1'b0;
      check("b2b_valid_drop", {31'd0, valid2}, 32'd0);
      scan_body(4'b0010);
      accept_frame();

      // Reset during channel 1
      mux_in2 = 4'b1101;
      start2  = 1'b1;
      tick();
      start2  = 1'b0;
      for (int n = 1; n < 6; n++) tick();
      check("mid_sel_ch1", {30'd0, s1_2, s0_2}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_sel", {30'd0, s1_2, s0_2}, 32'd0);
      check("mid_rst_data", {28'd0, data2}, 32'd0);
      check("mid_rst_busy", {31'd0, busy2}, 32'd0);
      check("mid_rst_valid", {31'd0, valid2}, 32'd0);
      held = 4'b0000;
      tick();
      #2 rst = 1'b0;
      for (int n = 0; n < 14; n++) begin
         tick();
         check("post_rst_novalid", {30'd0, valid2, busy2}, 32'd0);
      end
      start_scan(4'b1101, 4'b1101);
      accept_frame();

      // Zero settle time: selects step every cycle, frame after 4 edges
      mux_in0 = 4'b0110;
      start0  = 1'b1;
      tick();
      start0  = 1'b0;
      for (int n = 0; n < 4; n++) begin
         if (n > 0) tick();
         check("s0_sel_seq", {30'd0, s1_0, s0_0}, 32'(n));
         check("s0_busy", {31'd0, busy0}, 32'd1);
         check("s0_valid_low", {31'd0, valid0}, 32'd0);
      end
      tick();
      check("s0_valid_rise", {31'd0, valid0}, 32'd1);
      check("s0_frame_data", {28'd0, data0}, 32'b0110);
      tick();
      check("s0_valid_fall", {31'd0, valid0}, 32'd0);
      check("s0_busy_fall", {31'd0, busy0}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
